z_velocity_estimator: RTL and testbench
=======================================

Name: z_velocity_estimator

Overview:
- Upstream feeder of the auto mode controller's z_linear_velocity input.
- Integrates IMU vertical linear-acceleration samples into a leaky, saturating, signed vertical-velocity estimate.
- Publishes the estimate with a one-cycle valid strobe.
- Sits between the IMU data path and the auto mode controller; drives z_linear_velocity and, via velocity_valid, the controller's start strobe.

Parameters:
- DT_GAIN, 655: per-sample scale, round(0.01 s * 2^FRAC_BITS), for 100 Hz samples.
- FRAC_BITS, 16: fractional bits held in the accumulator.
- DEADBAND, 8: an acceleration with |a| <= DEADBAND (cm/s^2) is treated as 0.
- LEAK_SHIFT, 10: leak per sample is acc >>> LEAK_SHIFT.
- TIMEOUT_US, 50000: us_clk cycles without an accepted sample before the stale state.

Ports:
- us_clk  in  1  system microsecond clock.
- resetn  in  1  asynchronous active-low reset.
- z_linear_accel  in  16  signed vertical acceleration, 1 LSB = 1 cm/s^2.
- accel_valid  in  1  one-cycle strobe; z_linear_accel is valid in that cycle.
- imu_good  in  1  IMU calibration/health good.
- clear  in  1  synchronous zero request, e.g. when not in auto mode.
- z_linear_velocity  out  16  signed velocity estimate, cm/s.
- velocity_valid  out  1  one-cycle strobe; new estimate is available.
- stale  out  1  no accepted sample within TIMEOUT_US.
- saturated  out  1  accumulator clamped on the most recent update.
- debug  out  16  [15:8] dropped-sample count (saturating at 255), [7:5] state, [4] stale, [3] saturated, [2:0] 0.

Behaviour:
- Clock and reset: one clock, us_clk. Reset is asynchronous, active-low, on resetn.
- Reset values: all outputs 0, accumulator 0, state IDLE, timeout counter 0, dropped count 0.
- Accumulator: acc, 32-bit signed, velocity scaled by 2^FRAC_BITS.
- FSM states are IDLE, MULT, ACCUM, LEAK, OUT.
  - IDLE: accel_valid=1 and imu_good=1 accepts the sample and goes to MULT. accel_valid=1 with imu_good=0 is ignored; not counted as accepted or dropped.
  - MULT: register prod = a_db * DT_GAIN as 32-bit signed. a_db = 0 when |z_linear_accel| <= DEADBAND, otherwise z_linear_accel.
  - ACCUM: saturating add, acc + prod, clamped to [0x80000000, 0x7FFFFFFF]. saturated is set to 1 if the add clamped, else 0.
  - LEAK: acc <= acc - (acc >>> LEAK_SHIFT). The shift is arithmetic and rounds toward minus infinity.
  - OUT: z_linear_velocity <= acc >>> FRAC_BITS (bits [31:16]). velocity_valid=1 for this one cycle. Return to IDLE.
- Latency: accel_valid accepted in cycle N gives velocity_valid high in cycle N+4. Minimum sample spacing is 5 cycles.
- Busy: accel_valid arriving in MULT, ACCUM, LEAK or OUT is dropped, and the dropped count is incremented (saturating at 255).
- clear: highest priority below reset. In the same cycle it forces acc=0, z_linear_velocity=0, saturated=0, stale=0, timeout counter=0 and state IDLE. It aborts any in-flight update; no valid pulse is produced for it.
- Timeout counter:
  - Increments every cycle with no accepted sample and saturates at TIMEOUT_US.
  - Reset to 0 when a sample is accepted.
  - On reaching TIMEOUT_US: stale=1, acc=0, z_linear_velocity=0, no valid pulse.
  - The next accepted sample clears stale in its MULT cycle.
- z_linear_velocity changes only in OUT, on clear or on timeout. It is held otherwise.
- Simultaneous clear and accel_valid: clear wins and the sample is discarded, neither accepted nor counted as dropped.

Decomposition:
- Shared common_defines.v gets:
  - the FSM state encodings (ZVE_IDLE..ZVE_OUT, 3 bits);
  - ZVE_ACC_MAX and ZVE_ACC_MIN constants.
- One natural sub-module, sat_add32: a combinational signed 32-bit saturating adder with an overflow flag, used in ACCUM.

Test Plan:
- Reset: hold resetn=0 with us_clk running -> all outputs 0, debug=0; release resetn -> outputs stay 0 with no stimulus.
- Single sample: one accel_valid with accel=1000, imu_good=1 -> 4 cycles later velocity_valid=1 for one cycle, z_linear_velocity=9 (acc=654361), saturated=0.
- Deadband and health gating:
  - accel=8 -> valid pulse, velocity unchanged at 0.
  - accel=-9 -> acc=-5895+6=-5889, velocity=-1.
  - accel_valid with imu_good=0 -> no pulse, dropped count unchanged.
- Saturation and busy drop:
  - repeated accel=32767 every 5 cycles -> acc clamps, saturated=1, z_linear_velocity=32736.
  - a second accel_valid 2 cycles after an accepted one -> debug[15:8] increments by 1.
- Timeout and clear:
  - no samples for 50000 cycles -> stale=1, velocity=0; the next good sample clears stale.
  - clear asserted in ACCUM -> no valid pulse, acc=0, state IDLE next cycle.

Source files
------------

// File: rtl/z_velocity_estimator_pkg.sv
// Shared types and constants for the vertical-velocity estimator.
package z_velocity_estimator_pkg;

   localparam int unsigned DATA_W     = 16;
   localparam int unsigned ACC_W      = 32;
   localparam int unsigned FRAC_BITS  = 16;
   localparam int unsigned DT_GAIN    = 655;
   localparam int unsigned DEADBAND   = 8;
   localparam int unsigned LEAK_SHIFT = 10;
   localparam int unsigned TIMEOUT_US = 50000;
   localparam int unsigned TMO_W      = $clog2(TIMEOUT_US + 1);
   localparam int unsigned DROP_W     = 8;

   localparam logic signed [ACC_W-1:0]  ZVE_ACC_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [ACC_W-1:0]  ZVE_ACC_MIN = 32'sh8000_0000;
   localparam logic signed [ACC_W-1:0]  DT_GAIN_S   = ACC_W'(DT_GAIN);
   localparam logic signed [DATA_W-1:0] DB_HI       = DATA_W'(DEADBAND);
   localparam logic signed [DATA_W-1:0] DB_LO       = -DB_HI;

   typedef enum logic [2:0] {
      ZVE_IDLE  = 3'd0,
      ZVE_MULT  = 3'd1,
      ZVE_ACCUM = 3'd2,
      ZVE_LEAK  = 3'd3,
      ZVE_OUT   = 3'd4
   } zve_state_e;

   // Layout of the 16-bit debug word.
   typedef struct packed {
      logic [DROP_W-1:0] drop_cnt;
      zve_state_e        state;
      logic              stale;
      logic              saturated;
      logic [2:0]        rsvd;
   } zve_debug_t;

endpackage

// File: rtl/z_velocity_estimator_if.sv
// IMU-side inputs and controller-side outputs of the velocity estimator.
interface z_velocity_estimator_if;
   import z_velocity_estimator_pkg::*;

   logic signed [DATA_W-1:0] z_linear_accel;
   logic                     accel_valid;
   logic                     imu_good;
   logic                     clear;
   logic signed [DATA_W-1:0] z_linear_velocity;
   logic                     velocity_valid;
   logic                     stale;
   logic                     saturated;
   logic [15:0]              debug;

   modport master (
      output z_linear_accel, accel_valid, imu_good, clear,
      input  z_linear_velocity, velocity_valid, stale, saturated, debug
   );

   modport slave (
      input  z_linear_accel, accel_valid, imu_good, clear,
      output z_linear_velocity, velocity_valid, stale, saturated, debug
   );

endinterface

// File: rtl/z_velocity_estimator_sat_add32.sv
// Combinational signed 32-bit adder that clamps on overflow.
module z_velocity_estimator_sat_add32
   import z_velocity_estimator_pkg::*;
(
   input  logic signed [ACC_W-1:0] i_a,
   input  logic signed [ACC_W-1:0] i_b,
   output logic signed [ACC_W-1:0] o_sum_c,
   output logic                    o_ovf_c
);

   logic signed [ACC_W-1:0] w_raw;

   // Overflow only when both operands share a sign the result does not.
   always_comb begin
      w_raw   = i_a + i_b;
      o_ovf_c = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);
      o_sum_c = w_raw;
      if (o_ovf_c) begin
         o_sum_c = i_a[ACC_W-1] ? ZVE_ACC_MIN : ZVE_ACC_MAX;
      end
   end

endmodule

// File: rtl/z_velocity_estimator.sv
// Leaky saturating integrator turning IMU vertical acceleration into velocity.
module z_velocity_estimator
   import z_velocity_estimator_pkg::*;
(
   input  logic                   us_clk,
   input  logic                   resetn,
   z_velocity_estimator_if.slave  bus
);

   zve_state_e               r_state;
   zve_state_e               w_state_nxt;
   logic                     w_accept;
   logic                     w_drop;
   logic                     w_tmo_hit;

   logic signed [DATA_W-1:0] r_accel;
   logic signed [ACC_W-1:0]  r_prod;
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [DATA_W-1:0] r_vel;
   logic                     r_vvalid;
   logic                     r_stale;
   logic                     r_sat;
   logic [TMO_W-1:0]         r_tmo;
   logic [DROP_W-1:0]        r_drop;

   logic signed [DATA_W-1:0] w_a_db;
   logic signed [ACC_W-1:0]  w_a_ext;
   logic signed [ACC_W-1:0]  w_prod;
   logic signed [ACC_W-1:0]  w_sum;
   logic                     w_ovf;
   logic signed [ACC_W-1:0]  w_leak;
   zve_debug_t               w_debug;

   // Small accelerations are treated as sensor noise.
   assign w_a_db  = ((r_accel >= DB_LO) && (r_accel <= DB_HI)) ? '0 : r_accel;
   assign w_a_ext = {{(ACC_W-DATA_W){w_a_db[DATA_W-1]}}, w_a_db};
   assign w_prod  = w_a_ext * DT_GAIN_S;
   assign w_leak  = r_acc - (r_acc >>> LEAK_SHIFT);

   z_velocity_estimator_sat_add32 u_sat_add (
      .i_a     (r_acc),
      .i_b     (r_prod),
      .o_sum_c (w_sum),
      .o_ovf_c (w_ovf)
   );

   // State register.
   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ZVE_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, sample acceptance and busy-drop detection; clear overrides all.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_drop      = 1'b0;
      if (bus.clear) begin
         w_state_nxt = ZVE_IDLE;
      end else begin
         w_drop = bus.accel_valid && (r_state != ZVE_IDLE);
         case (r_state)
            ZVE_IDLE: begin
               if (bus.accel_valid && bus.imu_good) begin
                  w_accept    = 1'b1;
                  w_state_nxt = ZVE_MULT;
               end
            end
            ZVE_MULT:  w_state_nxt = ZVE_ACCUM;
            ZVE_ACCUM: w_state_nxt = ZVE_LEAK;
            ZVE_LEAK:  w_state_nxt = ZVE_OUT;
            ZVE_OUT:   w_state_nxt = ZVE_IDLE;
            default:   w_state_nxt = ZVE_IDLE;
         endcase
      end
   end

   // Timeout fires on the edge the counter reaches its limit.
   assign w_tmo_hit = !bus.clear && !w_accept && (r_tmo == TMO_W'(TIMEOUT_US - 1));

   // Datapath: product, accumulator, published estimate, flags and counters.
   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         r_accel  <= '0;
         r_prod   <= '0;
         r_acc    <= '0;
         r_vel    <= '0;
         r_vvalid <= 1'b0;
         r_stale  <= 1'b0;
         r_sat    <= 1'b0;
         r_tmo    <= '0;
         r_drop   <= '0;
      end else if (bus.clear) begin
         r_acc    <= '0;
         r_vel    <= '0;
         r_vvalid <= 1'b0;
         r_stale  <= 1'b0;
         r_sat    <= 1'b0;
         r_tmo    <= '0;
      end else begin
         r_vvalid <= 1'b0;
         if (w_accept) begin
            r_accel <= bus.z_linear_accel;
            r_tmo   <= '0;
         end else if (r_tmo != TMO_W'(TIMEOUT_US)) begin
            r_tmo <= r_tmo + TMO_W'(1);
         end
         if (w_drop && (r_drop != '1)) begin
            r_drop <= r_drop + DROP_W'(1);
         end
         case (r_state)
            ZVE_MULT: begin
               r_prod  <= w_prod;
               r_stale <= 1'b0;
            end
            ZVE_ACCUM: begin
               r_acc <= w_sum;
               r_sat <= w_ovf;
            end
            ZVE_LEAK: begin
               r_acc    <= w_leak;
               r_vel    <= DATA_W'(w_leak >>> FRAC_BITS);
               r_vvalid <= 1'b1;
            end
            default: ;
         endcase
         if (w_tmo_hit) begin
            r_stale <= 1'b1;
            r_acc   <= '0;
            r_vel   <= '0;
         end
      end
   end

   // Debug word is a straight view of registered state.
   assign w_debug = '{drop_cnt: r_drop, state: r_state, stale: r_stale,
                      saturated: r_sat, rsvd: 3'b000};

   assign bus.z_linear_velocity = r_vel;
   assign bus.velocity_valid    = r_vvalid;
   assign bus.stale             = r_stale;
   assign bus.saturated         = r_sat;
   assign bus.debug             = w_debug;

endmodule

// File: tb/tb_z_velocity_estimator.sv
// Bench for z_velocity_estimator: directed scenarios plus random traffic
// compared every cycle against a transaction-level arithmetic model.
module tb_z_velocity_estimator;

   localparam longint ACC_MAX  = 64'sd2147483647;
   localparam longint ACC_MIN  = -64'sd2147483648;
   localparam int     TIMEOUT  = 50000;

   logic us_clk = 1'b0;
   logic resetn = 1'b0;

   z_velocity_estimator_if bus ();

   z_velocity_estimator dut (
      .us_clk (us_clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 us_clk = ~us_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   longint m_acc, m_pend_acc, m_vel;
   int     m_phase, m_tmo, m_drop;
   bit     m_valid, m_stale, m_sat, m_pend_sat;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_pend_acc = 0; m_vel = 0;
      m_phase = 0; m_tmo = 0; m_drop = 0;
      m_valid = 0; m_stale = 0; m_sat = 0; m_pend_sat = 0;
   endtask

   // One clock edge of behaviour: the full update is computed at acceptance,
   // then its visible effects are released at the documented latencies.
   task automatic model_edge(input int a, input bit av, input bit good, input bit clr);
      longint adb, s;
      bit     ok;
      if (clr) begin
         m_acc = 0; m_vel = 0; m_sat = 0; m_stale = 0; m_tmo = 0;
         m_phase = 0; m_valid = 0;
      end else begin
         ok = (m_phase == 0) && av && good;
         if (m_phase != 0 && av && m_drop < 255) m_drop++;
         m_valid = 0;
         case (m_phase)
            1: m_stale = 0;
            2: m_sat = m_pend_sat;
            3: begin
               m_acc   = m_pend_acc;
               m_vel   = m_acc >>> 16;
               m_valid = 1;
            end
            default: ;
         endcase
         if (ok) begin
            adb = (a >= -8 && a <= 8) ? 0 : a;
            s = m_acc + adb * 655;
            m_pend_sat = 0;
            if (s > ACC_MAX) begin s = ACC_MAX; m_pend_sat = 1; end
            else if (s < ACC_MIN) begin s = ACC_MIN; m_pend_sat = 1; end
            m_pend_acc = s - (s >>> 10);
            m_phase = 1;
            m_tmo = 0;
         end else begin
            if (m_phase != 0) m_phase = (m_phase == 4) ? 0 : m_phase + 1;
            if (m_tmo < TIMEOUT) begin
               m_tmo++;
               if (m_tmo == TIMEOUT) begin
                  m_stale = 1; m_acc = 0; m_vel = 0;
               end
            end
         end
      end
   endtask

   task automatic cmp_all();
      logic [15:0] exp_dbg;
      exp_dbg = {8'(m_drop), 3'(m_phase), m_stale, m_sat, 3'b000};
      check("vel",   {16'h0, bus.z_linear_velocity}, {16'h0, 16'(m_vel)});
      check("valid", {31'h0, bus.velocity_valid},    {31'h0, m_valid});
      check("stale", {31'h0, bus.stale},             {31'h0, m_stale});
      check("sat",   {31'h0, bus.saturated},         {31'h0, m_sat});
      check("debug", {16'h0, bus.debug},             {16'h0, exp_dbg});
   endtask

   task automatic step(input int a, input bit av, input bit good, input bit clr);
      bus.z_linear_accel = 16'(a);
      bus.accel_valid    = av;
      bus.imu_good       = good;
      bus.clear          = clr;
      @(posedge us_clk);
      model_edge(a, av, good, clr);
      #1;
      cmp_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic sample(input int a);
      step(a, 1'b1, 1'b1, 1'b0);
      idle(3);
   endtask

   initial begin
      logic signed [15:0] r16;
      int ra;
      bus.z_linear_accel = '0;
      bus.accel_valid    = 1'b0;
      bus.imu_good       = 1'b0;
      bus.clear          = 1'b0;
      model_reset();

      // Reset values.
      repeat (3) @(posedge us_clk);
      #1;
      check("rst_vel",   {16'h0, bus.z_linear_velocity}, 32'h0);
      check("rst_valid", {31'h0, bus.velocity_valid},    32'h0);
      check("rst_stale", {31'h0, bus.stale},             32'h0);
      check("rst_sat",   {31'h0, bus.saturated},         32'h0);
      check("rst_debug", {16'h0, bus.debug},             32'h0);
      resetn = 1'b1;
      idle(3);

      // Single sample of 1000 cm/s^2.
      sample(1000);
      check("single_valid", {31'h0, bus.velocity_valid},    32'h1);
      check("single_vel",   {16'h0, bus.z_linear_velocity}, 32'd9);
      check("single_sat",   {31'h0, bus.saturated},         32'h0);
      idle(1);
      check("single_pulse_end", {31'h0, bus.velocity_valid}, 32'h0);

      // Deadband edge: 8 is zeroed, -9 passes.
      step(0, 1'b0, 1'b0, 1'b1);
      sample(8);
      check("db8_valid", {31'h0, bus.velocity_valid},    32'h1);
      check("db8_vel",   {16'h0, bus.z_linear_velocity}, 32'h0);
      idle(1);
      step(0, 1'b0, 1'b0, 1'b1);
      sample(-9);
      check("dbm9_vel", {16'h0, bus.z_linear_velocity}, 32'h0000_FFFF);
      idle(1);

      // Unhealthy IMU sample is ignored entirely.
      step(500, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         check("bad_imu_no_pulse", {31'h0, bus.velocity_valid}, 32'h0);
      idle(4);
      check("bad_imu_drop", {24'h0, bus.debug[15:8]}, 32'h0);

      // Saturation with full-scale input.
      step(0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 150; k++) begin
         sample(32767);
         idle(1);
      end
      check("sat_flag", {31'h0, bus.saturated},         32'h1);
      check("sat_vel",  {16'h0, bus.z_linear_velocity}, 32'd32736);

      // Busy drop: a second strobe two cycles after acceptance.
      step(100, 1'b1, 1'b1, 1'b0);
      idle(1);
      step(100, 1'b1, 1'b1, 1'b0);
      idle(3);
      check("busy_drop", {24'h0, bus.debug[15:8]}, 32'h1);

      // Clear during ACCUM aborts the update.
      step(0, 1'b0, 1'b0, 1'b1);
      step(2000, 1'b1, 1'b1, 1'b0);
      idle(1);
      step(0, 1'b0, 1'b1, 1'b1);
      check("clr_state", {29'h0, bus.debug[7:5]},       32'h0);
      check("clr_vel",   {16'h0, bus.z_linear_velocity}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         idle(1);
         check("clr_no_valid", {31'h0, bus.velocity_valid}, 32'h0);
      end

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if (($urandom % 4) == 0) r16 = 16'($urandom);
         else                     r16 = 16'($urandom_range(0, 400)) - 16'sd200;
         ra = r16;
         step(ra, ($urandom % 3) == 0, ($urandom % 8) != 0, ($urandom % 50) == 0);
      end

      // Timeout: exactly TIMEOUT cycles after the last acceptance.
      step(0, 1'b0, 1'b0, 1'b1);
      sample(1000);
      idle(1);
      idle(TIMEOUT - 5);
      check("tmo_not_yet", {31'h0, bus.stale}, 32'h0);
      idle(1);
      check("tmo_stale", {31'h0, bus.stale},             32'h1);
      check("tmo_vel",   {16'h0, bus.z_linear_velocity}, 32'h0);
      step(1000, 1'b1, 1'b1, 1'b0);
      check("tmo_stale_held", {31'h0, bus.stale}, 32'h1);
      idle(1);
      check("tmo_stale_clr", {31'h0, bus.stale}, 32'h0);
      idle(2);
      check("tmo_resume_valid", {31'h0, bus.velocity_valid},    32'h1);
      check("tmo_resume_vel",   {16'h0, bus.z_linear_velocity}, 32'd9);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
